// File: rtl/xdma_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one XDMA AXI-Stream sink through a one-entry output slice.
// Define XDMA_ARB_PKT_CNT_EN to add per-channel 32-bit completed-packet counters on pkt_cnt.
module xdma_stream_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 512,
    localparam int unsigned KEEP_W = DATA_W / 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   in_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]   in_tkeep,
    input  logic [NUM_CH-1:0]          in_tlast,
    input  logic [NUM_CH-1:0]          in_tvalid,
    output logic [NUM_CH-1:0]          in_tready,
    output logic [DATA_W-1:0]          out_tdata,
    output logic [KEEP_W-1:0]          out_tkeep,
    output logic                       out_tlast,
    output logic [7:0]                 out_tdest,
    output logic                       out_tvalid,
    input  logic                       out_tready
`ifdef XDMA_ARB_PKT_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]       pkt_cnt
`endif
);

    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     pick, cand;

    logic [DATA_W-1:0] out_tdata_q;
    logic [KEEP_W-1:0] out_tkeep_q;
    logic              out_tlast_q;
    logic [7:0]        out_tdest_q;
    logic              out_tvalid_q;

    logic              slot_free, accept, sel_tlast;
    logic [DATA_W-1:0] sel_tdata;
    logic [KEEP_W-1:0] sel_tkeep;

    assign slot_free = !out_tvalid_q || out_tready;
    assign sel_tdata = in_tdata[grant_q*DATA_W +: DATA_W];
    assign sel_tkeep = in_tkeep[grant_q*KEEP_W +: KEEP_W];
    assign sel_tlast = in_tlast[grant_q];
    assign accept    = (state_q == BUSY) && in_tvalid[grant_q] && slot_free;

    // Scan from the farthest candidate inward so the nearest valid channel above rr_ptr is written last.
    always_comb begin
        pick = rr_ptr_q;
        cand = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = GW'((32'(rr_ptr_q) + NUM_CH - 1 - k) % NUM_CH);
            if (in_tvalid[cand]) begin
                pick = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|in_tvalid) begin
                    state_d = BUSY;
                    grant_d = pick;
                end
            end
            BUSY: begin
                if (accept && sel_tlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = (32'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_tready = '0;
        if (state_q == BUSY) begin
            in_tready[grant_q] = slot_free;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tdest_q  <= '0;
            out_tvalid_q <= 1'b0;
        end else if (accept) begin
            out_tdata_q  <= sel_tdata;
            out_tkeep_q  <= sel_tkeep;
            out_tlast_q  <= sel_tlast;
            out_tdest_q  <= 8'(grant_q);
            out_tvalid_q <= 1'b1;
        end else if (out_tready) begin
            out_tvalid_q <= 1'b0;
        end
    end

    assign out_tdata  = out_tdata_q;
    assign out_tkeep  = out_tkeep_q;
    assign out_tlast  = out_tlast_q;
    assign out_tdest  = out_tdest_q;
    assign out_tvalid = out_tvalid_q;

`ifdef XDMA_ARB_PKT_CNT_EN
    logic [NUM_CH-1:0][31:0] pkt_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (accept && sel_tlast) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule
